uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit half of the UART: drains bytes from the transmit FIFO and serialises them onto the TX line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). The block sits between the TX FIFO and the TX pin. It is clocked by the UART clock and produces one bit every CLKS_PER_BIT clocks. It is the complement of the receive path that fills RcvData and pulses ByteRcv.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: UartClock cycles per serial bit. Legal range is 2..65535; elaboration fails outside this range.

Ports:
- UartClock, input, 1: sole clock; all state changes on its rising edge.
- nReset, input, 1: asynchronous, active-low reset.
- TxData, input, 8: head byte of the TX FIFO (first-word-fall-through); valid whenever TFcount != 0.
- TFcount, input, 4: TX FIFO occupancy; 0 means empty.
- TFdataRead, output, 1: one-cycle pop strobe to the TX FIFO; the byte on TxData is consumed on the same edge.
- TX, output, 1: serial line; idles high; registered.
- TxBusy, output, 1: high while a frame is in progress (state != IDLE).

## Operation
- States: IDLE, START, DATA, STOP. A clock counter (cnt, width ceil(log2(CLKS_PER_BIT))) and a 3-bit bit index (bitIdx).
- Reset (nReset=0, immediate): state=IDLE, TX=1, TxBusy=0, TFdataRead=0, cnt=0, bitIdx=0, shift register=0x00.
- TFdataRead = (state==IDLE) && (TFcount!=0) && nReset; combinational; never high outside IDLE.
- IDLE:
  - If TFcount!=0: on the edge, shift <= TxData, TX <= 0, cnt <= 0, state <= START.
  - Else: hold; TX=1.
- START: TX held 0. When cnt==CLKS_PER_BIT-1: cnt <= 0, bitIdx <= 0, TX <= shift[0], state <= DATA. Otherwise cnt++.
- DATA: TX carries shift[bitIdx]. When cnt==CLKS_PER_BIT-1:
  - If bitIdx==7: TX <= 1, state <= STOP.
  - Else: bitIdx++, TX <= shift[bitIdx+1].
  - In both cases cnt <= 0.
- STOP: TX held 1. When cnt==CLKS_PER_BIT-1: state <= IDLE, cnt <= 0.
- The shift register is loaded only in IDLE. TxData and TFcount are ignored in START, DATA and STOP; FIFO changes mid-frame have no effect on the frame in progress.
- Arithmetic: cnt wraps only by explicit clear, never by overflow. bitIdx never exceeds 7.

## Timing
- Edge E0: IDLE, TFcount!=0, TFdataRead=1. After E0: TX=0, TxBusy=1.
- Start bit: exactly CLKS_PER_BIT cycles. Each data bit: exactly CLKS_PER_BIT cycles. Stop bit: exactly CLKS_PER_BIT cycles.
- The frame occupies 10*CLKS_PER_BIT cycles of TX after E0. TxBusy falls on the same edge that ends the stop bit.
- Back-to-back frames: exactly one IDLE cycle (TX=1) separates frames. The frame period is 10*CLKS_PER_BIT+1 cycles, so the stop bit is effectively CLKS_PER_BIT+1 cycles long.
- Exactly one TFdataRead pulse per frame. No pop occurs when TFcount==0, including TFcount rising in the final STOP cycle; that byte is taken in the following IDLE cycle.
- Reset mid-frame: TX returns high asynchronously. The partial byte is discarded and not re-popped. After release, the first edge with TFcount!=0 begins a fresh frame.
- TFcount is assumed synchronous to UartClock; no internal synchroniser.

## Test plan
- Reset: nReset=0 with TFcount=3 → TX=1, TxBusy=0, TFdataRead=0 throughout. Release → TFdataRead pulses on the first clock.
- Single byte, CLKS_PER_BIT=16, TxData=0x55, TFcount 1→0 after pop → one TFdataRead pulse. TX sequence is 0,1,0,1,0,1,0,1,0,1, each 16 cycles (160 total). TxBusy high for 160 cycles, then TX stays 1.
- Back-to-back: FIFO holds 0xA3, 0x0F, TFcount=2 → two pops 161 cycles apart. TX carries 0xA3 (bits 1,1,0,0,0,1,0,1), then a 1-cycle idle, then 0x0F. A loopback into a reference receiver decodes 0xA3, 0x0F.
- Mid-frame FIFO change: TxData changes to 0xFF during DATA of 0x00 → transmitted bits remain 0x00; no extra TFdataRead.
- Mid-frame reset: nReset=0 at cycle 50 of a 0x00 frame → TX=1 in the same cycle. After release with TFcount=0: no pop, TX stays 1.
- Minimum divider, CLKS_PER_BIT=2, TxData=0x80 → frame lasts 20 cycles; bit 7 (value 1) is high for cycles 17-18; the stop bit is high for cycles 19-20.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmit serialiser: pops bytes from a first-word-fall-through TX FIFO
// and shifts them out as 8N1 frames, one bit every CLKS_PER_BIT clocks.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       UartClock,
    input  logic       nReset,
    input  logic [7:0] TxData,
    input  logic [3:0] TFcount,
    output logic       TFdataRead,
    output logic       TX,
    output logic       TxBusy
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_divider
        $error("uart_tx_serializer: CLKS_PER_BIT must be in 2..65535");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             cnt_last_s;
    logic             fifo_avail_s;

    assign cnt_last_s   = (cnt_q == CNT_LAST);
    assign fifo_avail_s = (TFcount != 4'd0);

    // Pop strobe is combinational so the FIFO head is consumed on the same edge it is loaded.
    assign TFdataRead = (state_q == ST_IDLE) && fifo_avail_s && nReset;
    assign TX         = tx_q;
    assign TxBusy     = busy_q;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_avail_s) begin
                    shift_d = TxData;
                    tx_d    = 1'b0;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_START;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_last_s) begin
                    cnt_d     = CNT_ZERO;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                    state_d   = ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_last_s) begin
                    cnt_d = CNT_ZERO;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_last_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset forces the line idle immediately.
    always_ff @(posedge UartClock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a FIFO model feeds two instances (divider 16 and 2);
// a frame-position reference model predicts TX, TxBusy and pops every cycle.
module tb_uart_tx_serializer;

    logic       clk;
    logic       nReset;
    logic [7:0] txd0, txd1;
    logic [3:0] tfc0, tfc1;
    logic       rd0, rd1, tx0, tx1, busy0, busy1;

    uart_tx_serializer #(.CLKS_PER_BIT(16)) dut16 (
        .UartClock(clk), .nReset(nReset), .TxData(txd0), .TFcount(tfc0),
        .TFdataRead(rd0), .TX(tx0), .TxBusy(busy0));

    uart_tx_serializer #(.CLKS_PER_BIT(2)) dut2 (
        .UartClock(clk), .nReset(nReset), .TxData(txd1), .TFcount(tfc1),
        .TFdataRead(rd1), .TX(tx1), .TxBusy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    int         dsel  = 0;       // which instance is being exercised
    logic [7:0] fifo[$];
    logic [7:0] idle_data = 8'h00;
    int         fc = 0;          // model: cycle position within frame, 0 = idle
    logic [7:0] cur = 8'h00;     // model: byte of frame in progress
    logic [7:0] rx_byte = 8'h00; // mid-bit loopback receiver

    function automatic int div();
        return (dsel == 0) ? 16 : 2;
    endfunction

    // Expected line level at frame cycle c: start bit, 8 data bits LSB first, stop bit.
    function automatic logic frame_bit(logic [7:0] b, int c, int n);
        int j;
        if (c == 0) return 1'b1;
        j = (c - 1) / n;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        return 1'b1;
    endfunction

    function automatic logic s_tx();   return (dsel == 0) ? tx0   : tx1;   endfunction
    function automatic logic s_rd();   return (dsel == 0) ? rd0   : rd1;   endfunction
    function automatic logic s_busy(); return (dsel == 0) ? busy0 : busy1; endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic drive();
        logic [3:0] cnt;
        logic [7:0] head;
        cnt  = (fifo.size() > 15) ? 4'd15 : 4'(fifo.size());
        head = (fifo.size() != 0) ? fifo[0] : idle_data;
        if (dsel == 0) begin
            tfc0 = cnt;  txd0 = head; tfc1 = 4'd0; txd1 = 8'h00;
        end else begin
            tfc1 = cnt;  txd1 = head; tfc0 = 4'd0; txd0 = 8'h00;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        drive();
    endtask

    // One clock: check outputs at the falling edge, then advance FIFO and model past the rising edge.
    task automatic cycle();
        int         n;
        logic       exp_pop, got_pop;
        logic [7:0] head;
        n = div();
        @(negedge clk);
        exp_pop = (fc == 0) && (fifo.size() != 0);
        chk("pop",  {7'd0, s_rd()},   {7'd0, exp_pop});
        chk("tx",   {7'd0, s_tx()},   {7'd0, frame_bit(cur, fc, n)});
        chk("busy", {7'd0, s_busy()}, {7'd0, (fc != 0)});
        if (fc >= 1 && (fc - 1) / n >= 1 && (fc - 1) / n <= 8 && ((fc - 1) % n) == n / 2)
            rx_byte[(fc - 1) / n - 1] = s_tx();
        if (fc == 10 * n) chk("rx_byte", rx_byte, cur);
        got_pop = s_rd();
        head    = (fifo.size() != 0) ? fifo[0] : idle_data;
        @(posedge clk);
        #1;
        if (got_pop && fifo.size() != 0) void'(fifo.pop_front());
        if (exp_pop) begin
            cur = head;
            fc  = 1;
        end else if (fc != 0) begin
            fc = (fc == 10 * n) ? 0 : fc + 1;
        end
        drive();
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic run_to_fc(input int target);
        int k;
        k = 0;
        while (fc != target && k < 2000) begin
            cycle();
            k++;
        end
        chk("wait_fc", {7'd0, (fc == target)}, 8'd1);
    endtask

    task automatic run_to_idle();
        int k;
        k = 0;
        while ((fc != 0 || fifo.size() != 0) && k < 5000) begin
            cycle();
            k++;
        end
        chk("wait_idle", {7'd0, (fc == 0 && fifo.size() == 0)}, 8'd1);
    endtask

    initial begin
        // Reset held with a non-empty FIFO: no pop, line idle.
        nReset = 1'b0;
        fifo.push_back(8'h55);
        fifo.push_back(8'hA3);
        fifo.push_back(8'h0F);
        drive();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_tx",   {7'd0, tx0},   8'd1);
            chk("rst_busy", {7'd0, busy0}, 8'd0);
            chk("rst_pop",  {7'd0, rd0},   8'd0);
        end
        @(posedge clk);
        #2 nReset = 1'b1;

        // 0x55 single, then 0xA3 and 0x0F back-to-back.
        run_to_idle();
        run(5);

        // TxData changes to 0xFF mid-frame and a byte arrives mid-frame.
        idle_data = 8'hFF;
        push(8'h00);
        run_to_fc(100);
        push(8'($urandom_range(255)));
        run_to_fc(10 * div());
        // This frame ends; byte arrives exactly in the final stop cycle.
        run_to_fc(1);
        run_to_fc(10 * div());
        push(8'($urandom_range(255)));
        run_to_idle();
        run(3);

        // Reset in the middle of a 0x00 frame.
        idle_data = 8'h00;
        push(8'h00);
        run_to_fc(50);
        #1 nReset = 1'b0;
        #1;
        chk("mid_rst_tx",   {7'd0, tx0},   8'd1);
        chk("mid_rst_busy", {7'd0, busy0}, 8'd0);
        chk("mid_rst_pop",  {7'd0, rd0},   8'd0);
        fc = 0;
        @(posedge clk);
        #2 nReset = 1'b1;
        run(40);

        // Randomised bytes with random gaps.
        for (int i = 0; i < 6; i++) begin
            push(8'($urandom_range(255)));
            if ($urandom_range(1) == 1) push(8'($urandom_range(255)));
            run(int'($urandom_range(200)));
        end
        run_to_idle();

        // Minimum divider instance.
        dsel = 1;
        drive();
        push(8'h80);
        run_to_idle();
        run(3);
        for (int i = 0; i < 4; i++) push(8'($urandom_range(255)));
        run(int'($urandom_range(30)) + 5);
        push(8'($urandom_range(255)));
        run_to_idle();
        run(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
